// File: rtl/contador_pkg.sv
// Shared encodings and constants for the Contador command sequencer.
// MODO values match the counter's own mode decoding.
package contador_pkg;

  localparam logic [1:0] MODO_UP   = 2'b00;
  localparam logic [1:0] MODO_DOWN = 2'b01;
  localparam logic [1:0] MODO_UP3  = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_REPORT
  } state_t;

  function automatic logic is_load(input logic [1:0] m);
    return m == MODO_LOAD;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// W-bit event counter that sticks at all-ones instead of wrapping.
// Synchronous clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/contador_ctrl.sv
// Command sequencer driving the cascaded counter's ENB/MODO/D.
// Reports final Q, RCO event count and a parity check per command.
module contador_ctrl
  import contador_pkg::*;
#(
  parameter int N  = 16,
  parameter int CW = 16,
  parameter int RW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic [1:0]    CMD_MODO,
  input  logic [N-1:0]  CMD_DATA,
  input  logic [CW-1:0] CMD_LEN,
  output logic          ENB,
  output logic [1:0]    MODO,
  output logic [N-1:0]  D,
  input  logic [N-1:0]  Q_IN,
  input  logic          RCO_IN,
  input  logic          PARIDAD_IN,
  output logic          BUSY,
  output logic          DONE,
  output logic [N-1:0]  Q_LAST,
  output logic [RW-1:0] RCO_CNT,
  output logic          PAR_ERR
);

  localparam int DW = $clog2(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_t          state;
  logic [CW-1:0]   len_cnt;
  logic [DW-1:0]   drain_cnt;
  logic            accept;
  logic            rco_inc;

  assign CMD_READY = (state == S_IDLE);
  assign BUSY      = (state != S_IDLE);
  assign accept    = CMD_VALID && CMD_READY;
  assign rco_inc   = RCO_IN && ((state == S_RUN) || (state == S_DRAIN));

  sat_counter #(
    .W(RW)
  ) u_rco (
    .clk(CLK),
    .rst(RST),
    .clr(accept),
    .inc(rco_inc),
    .cnt(RCO_CNT)
  );

  // Results are captured on the way into REPORT so they are valid with DONE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      len_cnt   <= '0;
      drain_cnt <= '0;
      ENB       <= 1'b0;
      MODO      <= MODO_UP;
      D         <= '0;
      DONE      <= 1'b0;
      Q_LAST    <= '0;
      PAR_ERR   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (CMD_VALID) begin
            PAR_ERR   <= 1'b0;
            len_cnt   <= CMD_LEN;
            drain_cnt <= DRAIN_LAST;
            if (is_load(CMD_MODO)) begin
              state <= S_LOAD;
              ENB   <= 1'b1;
              MODO  <= MODO_LOAD;
              D     <= CMD_DATA;
            end else if (CMD_LEN != '0) begin
              state <= S_RUN;
              ENB   <= 1'b1;
              MODO  <= CMD_MODO;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_LOAD: begin
          state <= S_DRAIN;
          ENB   <= 1'b0;
          MODO  <= MODO_UP;
        end
        S_RUN: begin
          if (len_cnt == CW'(1)) begin
            state <= S_DRAIN;
            ENB   <= 1'b0;
            MODO  <= MODO_UP;
          end else begin
            len_cnt <= len_cnt - CW'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state   <= S_REPORT;
            DONE    <= 1'b1;
            Q_LAST  <= Q_IN;
            PAR_ERR <= PARIDAD_IN ^ (^Q_IN);
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        S_REPORT: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/contador_ctrl.md
Name: contador_ctrl

Overview:
Command sequencer directly upstream of the 16-bit cascaded counter (Contador).
- Accepts counting commands over a valid/ready handshake.
- Drives the counter's ENB/MODO/D for a programmed number of cycles.
- Consumes the counter's Q/RCO/Paridad to report the final value, the carry count and a parity check.
- Lets software/testbench issue "load X, then count N steps" without cycle-accurate driving of ENB.

Parameters:
N, 16, counter data width (must match Contador N)
CW, 16, width of the cycle-length field
RW, 8, width of the saturating RCO event counter

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  asynchronous, active-high reset
CMD_VALID  in  1  command present
CMD_READY  out  1  block can accept a command (high only in IDLE)
CMD_MODO  in  2  00 up-by-1, 01 down-by-1, 10 up-by-3, 11 load
CMD_DATA  in  N  load value (used only when CMD_MODO=11)
CMD_LEN  in  CW  number of enabled count cycles (ignored for load)
ENB  out  1  to counter ENB, registered
MODO  out  2  to counter MODO, registered
D  out  N  to counter D, registered
Q_IN  in  N  counter Q
RCO_IN  in  1  counter RCO (registered inside counter)
PARIDAD_IN  in  1  counter Paridad
BUSY  out  1  high in any state other than IDLE
DONE  out  1  one-cycle pulse at command completion
Q_LAST  out  N  Q_IN captured at completion
RCO_CNT  out  RW  RCO_IN high-cycles seen during the command, saturating
PAR_ERR  out  1  captured PARIDAD_IN != XOR-reduce of captured Q_IN

Behaviour:
- Reset (async, immediate): state IDLE; ENB=0, MODO=00, D=0, DONE=0, Q_LAST=0, RCO_CNT=0, PAR_ERR=0, BUSY=0. CMD_READY=1 (it is state==IDLE).
- FSM states: IDLE, LOAD, RUN, DRAIN, REPORT.
- IDLE:
  - Accept on the rising edge with CMD_VALID & CMD_READY.
  - On accept: latch mode/data/len; clear RCO_CNT and PAR_ERR.
  - Next state: LOAD if mode=11; else RUN if len!=0; else DRAIN.
- LOAD: exactly one cycle with ENB=1, MODO=11, D=latched data. Next state DRAIN.
- RUN:
  - ENB=1 and MODO=latched mode for exactly len consecutive cycles.
  - First ENB-high cycle is the cycle after acceptance.
  - Internal down-counter loaded with len at accept; leave RUN when it reaches 1.
  - D holds the last value.
- DRAIN: ENB=0, MODO=00; lasts 2 cycles so the last count edge and the registered RCO have settled. Next state REPORT.
- REPORT (1 cycle):
  - DONE=1.
  - Q_LAST<=Q_IN.
  - PAR_ERR <= PARIDAD_IN ^ (^Q_IN).
  - Next state IDLE.
- RCO_CNT:
  - Increments by 1 each cycle RCO_IN=1 while in RUN or DRAIN.
  - Saturates at 2^RW-1; never wraps.
  - Held until the next accept.
- Q_LAST, PAR_ERR: held until the next REPORT (PAR_ERR is cleared on accept).
- Outputs while not in LOAD/RUN: ENB=0 in every other state; the counter is never enabled outside LOAD/RUN.
- Latency: accept → DONE = len+3 cycles (run/drain/report); load → 4 cycles; len=0 non-load → 3 cycles.
- CMD_VALID while BUSY: ignored; the command must stay valid until CMD_READY. No queuing.
- Reset mid-operation:
  - Aborts immediately, with ENB low asynchronously.
  - No DONE pulse; RCO_CNT/Q_LAST cleared.
- Full-width len (2^CW-1) must be supported without overflow of the internal counter.

Decomposition:
- Shared package contador_pkg:
  - MODO encodings (MODO_UP=2'b00, MODO_DOWN=2'b01, MODO_UP3=2'b10, MODO_LOAD=2'b11).
  - FSM state typedef.
  - DRAIN_CYCLES=2 constant.
- Sub-module sat_counter (RW-bit saturating incrementer with sync clear) is natural for RCO_CNT.
- Everything else stays in one module.

Test Plan:
- Load then up-count: load 0x1234 (DONE after 4 cycles), then up len=5 → Q_LAST=0x1239, RCO_CNT=0, PAR_ERR=0, ENB high exactly 5 cycles.
- Wrap: load 0xFFFE, up len=4 → Q_LAST=0x0002, RCO_CNT=1.
- Down wrap: load 0x0001, down len=3 → Q_LAST=0xFFFE, RCO_CNT=1.
- len=0 mode=00 → ENB never high, DONE exactly 3 cycles after accept, Q_LAST unchanged counter value.
- Backpressure: hold CMD_VALID high during a len=10 command → CMD_READY=0 throughout BUSY; second command accepted the cycle after DONE, never earlier.
- Reset mid-RUN at cycle 3 of len=8 → ENB=0 same cycle, BUSY=0, no DONE, RCO_CNT=0, CMD_READY=1; a fresh load 0x00FF then completes normally.
